// File: rtl/button_bit_conditioner_pkg.sv
// Shared types and constants for the push-button input stage and the password controller.
package button_bit_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    HELD         = 2'd1,
    WAIT_RELEASE = 2'd2
  } btnState_t;

  localparam logic BIT_FROM_A = 1'b0;
  localparam logic BIT_FROM_B = 1'b1;

  // Debounce interval in clock cycles; the controller derives its blink timing from the same constant.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/button_bit_conditioner_debounce_filter.sv
// Synchroniser plus stability counter for one raw active-low button.
module debounce_filter
  import button_bit_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rawN,
  output logic level,
  output logic settled
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] syncChain;
  logic [CNT_W-1:0]       stableCnt;
  logic                   syncLevel;

  assign syncLevel = syncChain[SYNC_STAGES-1];
  // settled means no level change is pending, so the debounced level reflects the pin
  assign settled   = (syncLevel == level);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncChain <= '1;
    end else begin
      syncChain <= {syncChain[SYNC_STAGES-2:0], rawN};
    end
  end

  // --- stability counter stage ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level     <= 1'b1;
      stableCnt <= '0;
    end else if (syncLevel == level) begin
      stableCnt <= '0;
    end else if (stableCnt == CNT_LAST) begin
      level     <= syncLevel;
      stableCnt <= '0;
    end else begin
      stableCnt <= stableCnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/button_bit_conditioner.sv
// Turns two bouncing active-low buttons into one bit event per press, with chord detection
// and a release lockout so the password controller sees only clean events.
module button_bit_conditioner
  import button_bit_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_a_n,
  input  logic btn_b_n,
  output logic bit_valid,
  output logic bit_value,
  output logic chord_err,
  output logic held
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 1);

  logic levelA, levelB, settledA, settledB;
  logic pa, pb;
  logic [ARM_W-1:0] armCnt;
  logic armed;
  btnState_t state, stateNext;
  logic bitValid_p0, bitValue_p0, chordErr_p0;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) uFilterA (
    .clk    (clk),
    .rst_n  (rst_n),
    .rawN   (btn_a_n),
    .level  (levelA),
    .settled(settledA)
  );

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) uFilterB (
    .clk    (clk),
    .rst_n  (rst_n),
    .rawN   (btn_b_n),
    .level  (levelB),
    .settled(settledB)
  );

  assign pa = ~levelA;
  assign pb = ~levelB;

  // The synchronisers restart at "released", so a button held through reset only becomes
  // visible once the chain has refilled; WAIT_RELEASE must not trust the filters before that.
  assign armed = (armCnt == ARM_W'(SYNC_STAGES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armCnt <= '0;
    end else if (!armed) begin
      armCnt <= armCnt + ARM_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_RELEASE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:         if (pa || pb) stateNext = HELD;
      HELD:         if (!pa && !pb) stateNext = IDLE;
      WAIT_RELEASE: if (armed && !pa && !pb && settledA && settledB) stateNext = IDLE;
      default:      stateNext = WAIT_RELEASE;
    endcase
  end

  always_comb begin
    bitValid_p0 = 1'b0;
    bitValue_p0 = bit_value;
    chordErr_p0 = 1'b0;
    if (state == IDLE) begin
      if (pa && pb) begin
        chordErr_p0 = 1'b1;
      end else if (pa) begin
        bitValid_p0 = 1'b1;
        bitValue_p0 = BIT_FROM_A;
      end else if (pb) begin
        bitValid_p0 = 1'b1;
        bitValue_p0 = BIT_FROM_B;
      end
    end
  end

  // --- registered event outputs ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_valid <= 1'b0;
      bit_value <= 1'b0;
      chord_err <= 1'b0;
    end else begin
      bit_valid <= bitValid_p0;
      bit_value <= bitValue_p0;
      chord_err <= chordErr_p0;
    end
  end

  assign held = (state != IDLE) || pa || pb;

endmodule

// File: tb/tb_button_bit_conditioner.sv
// Directed bench for button_bit_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_button_bit_conditioner;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic btn_a_n = 1'b1;
  logic btn_b_n = 1'b1;
  logic bit_valid, bit_value, chord_err, held;

  int total = 0;
  int bad = 0;

  logic bits[$];
  int chordCnt = 0;
  int bothCnt = 0;
  int wideCnt = 0;
  logic prevValid = 1'b0;

  button_bit_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_a_n  (btn_a_n),
    .btn_b_n  (btn_b_n),
    .bit_valid(bit_valid),
    .bit_value(bit_value),
    .chord_err(chord_err),
    .held     (held)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bit_valid) bits.push_back(bit_value);
      if (chord_err) chordCnt++;
      if (bit_valid && chord_err) bothCnt++;
      if (bit_valid && prevValid) wideCnt++;
      prevValid = bit_valid;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pressRelease(input logic useB);
    if (useB) btn_b_n = 1'b0; else btn_a_n = 1'b0;
    step(10);
    if (useB) btn_b_n = 1'b1; else btn_a_n = 1'b1;
    step(10);
  endtask

  initial begin
    int base;
    logic [5:0] seq;

    #1 rst_n = 1'b0;
    #2;
    check("rst_held", held, 1);
    check("rst_valid", bit_valid, 0);
    check("rst_value", bit_value, 0);
    check("rst_chord", chord_err, 0);
    step(2);
    rst_n = 1'b1;
    step(6);
    @(negedge clk);
    check("idle_held", held, 0);

    // clean A press: debounced at edge 5, pulse after edge 6
    step(1);
    base = bits.size();
    btn_a_n = 1'b0;
    step(5);
    @(negedge clk);
    check("a_held_e4", held, 0);
    step(1);
    @(negedge clk);
    check("a_valid_e5", bit_valid, 0);
    check("a_held_e5", held, 1);
    step(1);
    @(negedge clk);
    check("a_valid_e6", bit_valid, 1);
    check("a_value_e6", bit_value, 0);
    step(1);
    @(negedge clk);
    check("a_valid_e7", bit_valid, 0);
    step(3);
    btn_a_n = 1'b1;
    step(6);
    @(negedge clk);
    check("a_rel_held_e5", held, 1);
    step(1);
    @(negedge clk);
    check("a_rel_held_e6", held, 0);
    step(8);
    check("a_one_pulse", bits.size() - base, 1);

    // bounce rejection on B
    base = bits.size();
    for (int i = 0; i < 10; i++) begin
      btn_b_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(2);
    end
    check("b_bounce_none", bits.size() - base, 0);
    btn_b_n = 1'b0;
    step(6);
    @(negedge clk);
    check("b_valid_e5", bit_valid, 0);
    step(1);
    @(negedge clk);
    check("b_valid_e6", bit_valid, 1);
    check("b_value_e6", bit_value, 1);
    step(4);
    btn_b_n = 1'b1;
    step(10);
    check("b_one_pulse", bits.size() - base, 1);

    // chord
    base = bits.size();
    btn_a_n = 1'b0;
    btn_b_n = 1'b0;
    step(7);
    @(negedge clk);
    check("chord_err", chord_err, 1);
    check("chord_novalid", bit_valid, 0);
    check("chord_held", held, 1);
    step(1);
    @(negedge clk);
    check("chord_one_cycle", chord_err, 0);
    btn_a_n = 1'b1;
    step(10);
    check("chord_held_b", held, 1);
    btn_b_n = 1'b1;
    step(7);
    @(negedge clk);
    check("chord_released", held, 0);
    step(3);
    check("chord_no_bits", bits.size() - base, 0);
    check("chord_count", chordCnt, 1);

    // overlap lockout
    base = bits.size();
    btn_a_n = 1'b0;
    step(10);
    btn_b_n = 1'b0;
    step(10);
    btn_a_n = 1'b1;
    btn_b_n = 1'b1;
    step(10);
    pressRelease(1'b1);
    check("ovl_count", bits.size() - base, 2);
    if (bits.size() - base == 2) begin
      check("ovl_first", bits[base], 0);
      check("ovl_second", bits[base+1], 1);
    end
    check("ovl_no_chord", chordCnt, 1);

    // reset while A held
    btn_a_n = 1'b0;
    step(10);
    rst_n = 1'b0;
    #1;
    check("rst_async_held", held, 1);
    check("rst_async_valid", bit_valid, 0);
    step(3);
    rst_n = 1'b1;
    base = bits.size();
    step(20);
    @(negedge clk);
    check("rsthold_held", held, 1);
    check("rsthold_no_bits", bits.size() - base, 0);
    step(1);
    btn_a_n = 1'b1;
    step(10);
    check("rsthold_released", bits.size() - base, 0);
    pressRelease(1'b1);
    check("rsthold_b_count", bits.size() - base, 1);
    if (bits.size() - base == 1) check("rsthold_b_value", bits[base], 1);

    // six-press sequence A,B,B,A,B,A (bit i of seq is press i)
    seq = 6'b010110;
    base = bits.size();
    for (int i = 0; i < 6; i++) pressRelease(seq[i]);
    check("seq_count", bits.size() - base, 6);
    if (bits.size() - base == 6) begin
      for (int i = 0; i < 6; i++) check($sformatf("seq_bit%0d", i), bits[base+i], seq[i]);
    end
    check("pulse_width", wideCnt, 0);
    check("valid_chord_excl", bothCnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_bit_conditioner.md
Name: button_bit_conditioner

Overview:
- Upstream input stage for the password entry/verify controller.
- Takes the two raw, active-low, bouncing push-buttons and synchronises and debounces them. Emits exactly one single-cycle bit event per physical press: button A gives bit 0, button B gives bit 1.
- Enforces press/release lockout in one place so the controller only counts clean events.
- Flags two-button chords separately; a chord never produces a bit.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles needed to accept a level change. Minimum 1.
- SYNC_STAGES, 2: synchroniser flops per button. Minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- btn_a_n  input  1  raw button A, 0 = pressed, asynchronous
- btn_b_n  input  1  raw button B, 0 = pressed, asynchronous
- bit_valid  output  1  one-cycle pulse: a bit was entered
- bit_value  output  1  entered bit (0 = A, 1 = B); meaningful only while bit_valid = 1
- chord_err  output  1  one-cycle pulse: both buttons were accepted as pressed in the same cycle
- held  output  1  1 while any debounced button is pressed, or while the FSM is awaiting release

Behaviour:
- Reset (rst_n low, asynchronous):
  - synchroniser flops = 1 (released); debounced levels = released; debounce counters = 0
  - FSM = WAIT_RELEASE
  - bit_valid = 0, bit_value = 0, chord_err = 0, held = 1
- Synchroniser: SYNC_STAGES flops per button, reset to 1.
- Debounce, per button, independent:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - When the synchronised level equals the debounced level, the counter clears to 0.
  - When it differs, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the level still differs, the debounced level flips on that edge and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count and produces no output.
- Latency: a clean raw level change sampled first at edge 0 flips the debounced level at edge SYNC_STAGES+DEBOUNCE_CYCLES-1. bit_valid is high for the cycle following edge SYNC_STAGES+DEBOUNCE_CYCLES. The release path has the same latency.
- FSM on the debounced pair (pa, pb = pressed):
  - IDLE:
    - pa and not pb: bit_valid=1, bit_value=0, go to HELD.
    - pb and not pa: bit_valid=1, bit_value=1, go to HELD.
    - pa and pb in the same cycle: chord_err=1, no bit_valid, go to HELD.
    - Neither pressed: stay in IDLE.
  - HELD:
    - Pressing the second button while the first is held is ignored: no bit, no chord_err.
    - Leave only when both buttons are released; then go to IDLE.
  - WAIT_RELEASE (entered only from reset):
    - Go to IDLE once both debounced levels read released for one cycle.
    - A button held through reset deassertion therefore never produces a spurious bit.
- Output timing:
  - bit_valid and chord_err are registered and never both high.
  - Minimum spacing between bit_valid pulses is two full debounce intervals (one release, one press).
  - bit_value holds its last value between pulses.
  - held = (FSM != IDLE) or pa or pb.
- No back-pressure: the downstream controller must accept bit_valid in the cycle it is asserted.
- Reset mid-debounce or mid-press aborts any pending event; no pulse is emitted after reset for a press that began before reset.

Decomposition:
- Shared package:
  - FSM state typedef: IDLE, HELD, WAIT_RELEASE.
  - Bit-encoding constants: BIT_FROM_A = 0, BIT_FROM_B = 1.
  - Default debounce constant, shared with the controller's blink timing constants.
- Sub-module debounce_filter (parameters DEBOUNCE_CYCLES, SYNC_STAGES): one raw input in, one debounced level out, covering synchroniser and counter. Instantiate it twice.
- FSM and output registers live in the top.

Test Plan:
- Use DEBOUNCE_CYCLES=4 and SYNC_STAGES=2 for all directed scenarios.
- Clean A press: btn_a_n 1→0 at edge 0 and held → exactly one bit_valid pulse with bit_value=0 in the cycle after edge 6. Release, then hold 8 cycles → no further pulse.
- Bounce rejection: btn_b_n toggles 0/1 every 2 cycles for 20 cycles, then stays 0 → no pulse during the toggling. Exactly one bit_valid with bit_value=1 occurs 6 edges after the final 1→0.
- Chord: btn_a_n and btn_b_n fall at the same edge → one chord_err pulse, bit_valid stays 0, held=1 until both released.
- Overlap lockout: press A, wait 10 cycles, press B while A held, release both, then press B alone → sequence is bit 0, then bit 1. No event is produced for the overlapped B press.
- Reset while held: hold A, pulse rst_n low for 3 cycles, keep A held 20 cycles → no bit_valid, held=1. Release A, then press B → bit_valid with bit_value=1.
- Six-press sequence A,B,B,A,B,A with 10-cycle gaps → six bit_valid pulses carrying 0,1,1,0,1,0 in order, each exactly one cycle wide.
